// File: rtl/lcd_timing_driver.sv
// RGB LCD timing generator and pixel sink: scan counters, one-cycle-ahead pixel
// requests, registered panel syncs/data-enable and frame-gated display enable.
module lcd_timing_driver #(
  parameter logic [10:0] H_SYNC  = 11'd128,
  parameter logic [10:0] H_BACK  = 11'd88,
  parameter logic [10:0] H_DISP  = 11'd800,
  parameter logic [10:0] H_FRONT = 11'd40,
  parameter logic [10:0] V_SYNC  = 11'd2,
  parameter logic [10:0] V_BACK  = 11'd33,
  parameter logic [10:0] V_DISP  = 11'd480,
  parameter logic [10:0] V_FRONT = 11'd10,
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        disp_en,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        sof,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] HA      = H_SYNC + H_BACK;
  localparam logic [10:0] VA      = V_SYNC + V_BACK;
  localparam logic [10:0] H_END   = HA + H_DISP - 11'd1;
  localparam logic [10:0] V_END   = VA + V_DISP - 11'd1;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        frm_en;
  logic        h_last;
  logic        v_last;
  logic        h_act;
  logic        v_act;
  logic        origin;

  // Counter decodes shared by the scan, request and sync logic
  always_comb begin
    h_last = (h_cnt == H_TOTAL - 11'd1);
    v_last = (v_cnt == V_TOTAL - 11'd1);
    h_act  = (h_cnt >= HA) && (h_cnt <= H_END);
    v_act  = (v_cnt >= VA) && (v_cnt <= V_END);
    origin = (h_cnt == 11'd0) && (v_cnt == 11'd0);
  end

  // Horizontal/vertical scan counters
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else begin
      if (h_last) begin
        h_cnt <= 11'd0;
        v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Enable only changes on the very last clock of a frame, so frames are never torn
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frm_en <= 1'b0;
    end else if (h_last && v_last) begin
      frm_en <= disp_en;
    end
  end

  // Request is issued one clock ahead of display; coordinates are zero outside it
  always_comb begin
    data_req   = h_act && v_act && frm_en;
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd0;
    if (data_req) begin
      pixel_xpos = h_cnt - HA;
      pixel_ypos = v_cnt - VA;
    end
  end

  // Panel syncs and data enable, registered to line up with the returned pixel
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lcd_hs <= ~HS_POL;
      lcd_vs <= ~VS_POL;
      lcd_de <= 1'b0;
    end else begin
      lcd_hs <= (h_cnt < H_SYNC) ? HS_POL : ~HS_POL;
      lcd_vs <= (v_cnt < V_SYNC) ? VS_POL : ~VS_POL;
      lcd_de <= data_req;
    end
  end

  // Start-of-frame pulse and free-running frame counter
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sof       <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      sof <= origin;
      if (origin) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign lcd_rgb = lcd_de ? pixel_data : 16'h0000;
  assign lcd_bl  = frm_en;

endmodule
